clk_div_sched: RTL and testbench

CLK_DIV_SCHED -- requirements
Module: clk_div_sched

---
 rtl/clk_div_sched_if.sv | 21 ++
 rtl/clk_div_sched.sv | 114 +++++++++++
 tb/tb_clk_div_sched.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_sched_if.sv
// Divisor-request handshake bundle for clk_div_sched: two requesters offering a new divide ratio.
interface clk_div_sched_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_div;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_div;
  logic             req1_ready;

  modport master (
    output req0_valid, req0_div, req1_valid, req1_div,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_div, req1_valid, req1_div,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/clk_div_sched.sv
// Programmable clock divider; new divide ratios arrive from two round-robin requesters
// and take effect only on a period boundary (or immediately while idle).
module clk_div_sched #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  clk_div_sched_if.slave   req,
  output logic             clk_out,
  output logic             period_done,
  output logic [WIDTH-1:0] cur_div,
  output logic             pending,
  output logic             cfg_err
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] cur_div_q, cur_div_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             pending_q, pending_d;
  logic             ptr_q, ptr_d;
  logic             clk_out_q, clk_out_d;
  logic             period_done_q, period_done_d;
  logic             cfg_err_q, cfg_err_d;

  logic             can_accept, grant0, grant1, boundary, apply;
  logic [WIDTH-1:0] acc_div;

  // Only one divisor may be outstanding; ptr_q picks the winner when both ask.
  always_comb begin
    can_accept     = reset && !pending_q;
    req.req0_ready = can_accept && (!ptr_q || !req.req1_valid);
    req.req1_ready = can_accept && (ptr_q || !req.req0_valid);
    grant0         = req.req0_valid && req.req0_ready;
    grant1         = req.req1_valid && req.req1_ready && !grant0;
    acc_div        = grant0 ? req.req0_div : req.req1_div;
  end

  always_comb begin
    state_d       = enable ? RUN : IDLE;
    count_d       = '0;
    cur_div_d     = cur_div_q;
    pend_div_d    = pend_div_q;
    pending_d     = pending_q;
    ptr_d         = ptr_q;
    cfg_err_d     = 1'b0;
    boundary      = (state_q == RUN) && (count_q == cur_div_q - ONE);
    apply         = pending_q && (boundary || (state_q == IDLE));

    if ((state_q == RUN) && (state_d == RUN) && !boundary) begin
      count_d = count_q + ONE;
    end

    // Grants need pending_q low and apply needs it high, so they never collide.
    if (apply) begin
      cur_div_d = pend_div_q;
      count_d   = '0;
      pending_d = 1'b0;
    end

    if (grant0 || grant1) begin
      ptr_d = grant0;
      if (acc_div >= TWO) begin
        pend_div_d = acc_div;
        pending_d  = 1'b1;
      end else begin
        cfg_err_d  = 1'b1;
      end
    end

    // Outputs are registered, so they are computed from the next-cycle count.
    clk_out_d     = (state_d == RUN) && (count_d >= (cur_div_d >> 1));
    period_done_d = (state_d == RUN) && (count_d == cur_div_d - ONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      cur_div_q     <= DIV_RST;
      pend_div_q    <= '0;
      pending_q     <= 1'b0;
      ptr_q         <= 1'b0;
      clk_out_q     <= 1'b0;
      period_done_q <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      cur_div_q     <= cur_div_d;
      pend_div_q    <= pend_div_d;
      pending_q     <= pending_d;
      ptr_q         <= ptr_d;
      clk_out_q     <= clk_out_d;
      period_done_q <= period_done_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign clk_out     = clk_out_q;
  assign period_done = period_done_q;
  assign cur_div     = cur_div_q;
  assign pending     = pending_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_clk_div_sched.sv
// Scoreboard bench for clk_div_sched: directed scenarios push expected periods, grants
// and cfg_err pulses; a forked monitor pops and compares as the DUT produces them.
module tb_clk_div_sched;

  typedef struct { int div; int lo; int hi; } period_t;
  typedef struct { int port; int div; }       grant_t;
  typedef struct { int div; int pend; }       cfg_t;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       clk_out;
  logic       period_done;
  logic [7:0] cur_div;
  logic       pending;
  logic       cfg_err;

  int checks = 0;
  int errors = 0;

  period_t pq[$];
  grant_t  gq[$];
  cfg_t    cq[$];

  clk_div_sched_if #(.WIDTH(8)) rif ();

  clk_div_sched #(.WIDTH(8), .DEFAULT_DIV(12)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .enable      (enable),
    .req         (rif),
    .clk_out     (clk_out),
    .period_done (period_done),
    .cur_div     (cur_div),
    .pending     (pending),
    .cfg_err     (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_period(input int div, input int n);
    period_t p;
    p.div = div;
    p.lo  = div / 2;
    p.hi  = div - div / 2;
    for (int i = 0; i < n; i++) pq.push_back(p);
  endtask

  task automatic push_grant(input int port, input int div);
    grant_t g;
    g.port = port;
    g.div  = div;
    gq.push_back(g);
  endtask

  task automatic grant_pop(input int port, input int div);
    grant_t g;
    if (gq.size() == 0) begin
      chk("grant_expected", gq.size(), 1);
    end else begin
      g = gq.pop_front();
      chk("grant_port", port, g.port);
      chk("grant_div", div, g.div);
    end
  endtask

  task automatic wait_pd(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      seen = period_done;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s actual=no_period_done required=period_done", name);
    end
  endtask

  task automatic handshake(input string name);
    bit g0;
    bit g1;
    bit done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      g0 = rif.req0_valid && rif.req0_ready;
      g1 = rif.req1_valid && rif.req1_ready;
      step();
      if (g0) rif.req0_valid = 1'b0;
      if (g1) rif.req1_valid = 1'b0;
      done = !rif.req0_valid && !rif.req1_valid;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s actual=not_granted required=granted", name);
      rif.req0_valid = 1'b0;
      rif.req1_valid = 1'b0;
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_clk_out"}, int'(clk_out), 0);
    chk({tag, "_period_done"}, int'(period_done), 0);
    chk({tag, "_cfg_err"}, int'(cfg_err), 0);
    chk({tag, "_pending"}, int'(pending), 0);
    chk({tag, "_cur_div"}, int'(cur_div), 12);
    chk({tag, "_ready0"}, int'(rif.req0_ready), 0);
    chk({tag, "_ready1"}, int'(rif.req1_ready), 0);
  endtask

  task automatic monitor();
    bit      prev_en = 1'b0;
    int      lo = 0;
    int      hi = 0;
    period_t pe;
    cfg_t    ce;
    forever begin
      @(negedge clk);
      if (rst_n && prev_en) begin
        if (clk_out) hi++; else lo++;
        if (period_done) begin
          if (pq.size() == 0) begin
            chk("period_expected", pq.size(), 1);
          end else begin
            pe = pq.pop_front();
            chk("period_div", int'(cur_div), pe.div);
            chk("period_low", lo, pe.lo);
            chk("period_high", hi, pe.hi);
          end
          lo = 0;
          hi = 0;
        end
      end else begin
        lo = 0;
        hi = 0;
        if (period_done) chk("period_done_idle", int'(period_done), 0);
        if (clk_out)     chk("clk_out_idle", int'(clk_out), 0);
      end
      if (rif.req0_valid && rif.req0_ready) grant_pop(0, int'(rif.req0_div));
      if (rif.req1_valid && rif.req1_ready) grant_pop(1, int'(rif.req1_div));
      if (cfg_err) begin
        if (cq.size() == 0) begin
          chk("cfg_err_expected", cq.size(), 1);
        end else begin
          ce = cq.pop_front();
          chk("cfg_err_cur_div", int'(cur_div), ce.div);
          chk("cfg_err_pending", int'(pending), ce.pend);
        end
      end
      prev_en = rst_n && enable;
    end
  endtask

  initial begin
    cfg_t c;
    rst_n          = 1'b0;
    enable         = 1'b0;
    rif.req0_valid = 1'b1;
    rif.req0_div   = 8'd9;
    rif.req1_valid = 1'b1;
    rif.req1_div   = 8'd10;
    fork
      monitor();
    join_none

    // Reset values, then free-running divide-by-12
    repeat (2) step();
    check_reset("rst");
    rif.req0_valid = 1'b0;
    rif.req1_valid = 1'b0;
    step();
    rst_n  = 1'b1;
    enable = 1'b1;
    push_period(12, 3);
    repeat (3) wait_pd("div12_run");
    chk("div12_cur_div", int'(cur_div), 12);

    // Enable drops at count 7 with N=6 pending; applied while idle
    step();
    rif.req0_div   = 8'd6;
    rif.req0_valid = 1'b1;
    push_grant(0, 6);
    handshake("req0_n6");
    repeat (6) step();
    enable = 1'b0;
    @(negedge clk);
    chk("drop_last_high", int'(clk_out), 1);
    step();
    @(negedge clk);
    chk("idle_clk_out", int'(clk_out), 0);
    chk("idle_cur_div_old", int'(cur_div), 12);
    chk("idle_pending", int'(pending), 1);
    step();
    @(negedge clk);
    chk("idle_cur_div_new", int'(cur_div), 6);
    chk("idle_pending_clr", int'(pending), 0);
    step();
    enable = 1'b1;
    push_period(6, 2);
    repeat (2) wait_pd("div6_run");

    // N=5 mid-period: current 6-period completes, then 2 low / 3 high
    step();
    step();
    step();
    rif.req0_div   = 8'd5;
    rif.req0_valid = 1'b1;
    push_grant(0, 5);
    push_period(6, 1);
    push_period(5, 2);
    handshake("req0_n5");
    @(negedge clk);
    chk("n5_pending", int'(pending), 1);
    repeat (3) wait_pd("div5_run");
    chk("n5_cur_div", int'(cur_div), 5);

    // Illegal N=1 from req1: cfg_err pulse, nothing changes
    step();
    rif.req1_div   = 8'd1;
    rif.req1_valid = 1'b1;
    push_grant(1, 1);
    c.div  = 5;
    c.pend = 0;
    cq.push_back(c);
    handshake("req1_n1");
    @(negedge clk);
    chk("n1_pending", int'(pending), 0);
    chk("n1_cur_div", int'(cur_div), 5);
    push_period(5, 1);
    wait_pd("n1_period");

    // Both requesters at once: req0 (N=4) first, req1 (N=8) right after N=4 applies
    step();
    rif.req0_div   = 8'd4;
    rif.req0_valid = 1'b1;
    rif.req1_div   = 8'd8;
    rif.req1_valid = 1'b1;
    push_grant(0, 4);
    push_grant(1, 8);
    push_period(5, 1);
    push_period(4, 1);
    push_period(8, 2);
    handshake("both_req");
    repeat (3) wait_pd("rr_run");
    chk("rr_cur_div", int'(cur_div), 8);

    // Async reset mid-period with N=3 pending: everything back to reset values
    step();
    rif.req0_div   = 8'd3;
    rif.req0_valid = 1'b1;
    push_grant(0, 3);
    handshake("req0_n3");
    step();
    step();
    #2;
    rst_n          = 1'b0;
    rif.req1_div   = 8'd7;
    rif.req1_valid = 1'b1;
    #1;
    check_reset("async_rst");
    rif.req1_valid = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    push_period(12, 1);
    wait_pd("post_reset");
    chk("post_reset_cur_div", int'(cur_div), 12);
    chk("post_reset_pending", int'(pending), 0);

    repeat (3) step();
    chk("period_queue_empty", pq.size(), 0);
    chk("grant_queue_empty", gq.size(), 0);
    chk("cfg_queue_empty", cq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
